// File: rtl/turbo_len_ctrl.sv
// Frame-length / lane-enable generator for the turbo interleaver: maps link_id to a block
// length and walks the frame LANES bits per beat, emitting lane mask, beat index and strobe.
module turbo_len_ctrl #(
  parameter int unsigned LANES    = 16,
  parameter int unsigned ID_W     = 6,
  parameter int unsigned LEN_W    = 13,
  parameter int unsigned JUMP_W   = 16,
  parameter int unsigned BASE_LEN = 40,
  parameter int unsigned LEN_STEP = 64
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              request_i,
  input  logic              abort_i,
  input  logic              mode_i,
  input  logic [ID_W-1:0]   link_id_i,
  input  logic              din_vld_i,
  output logic [LANES-1:0]  enable_o,
  output logic [JUMP_W-1:0] id_jump_o,
  output logic              wen_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  m_len_o
);

  localparam int unsigned LaneW = $clog2(LANES);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ID_W-1:0]     link_q, link_d;
  logic [LEN_W-1:0]    m_len_q, m_len_d;
  logic [JUMP_W-1:0]   last_idx_q, last_idx_d;
  logic [LANES-1:0]    last_en_q, last_en_d;
  logic [JUMP_W-1:0]   beat_q, beat_d;
  logic [LANES-1:0]    enable_q, enable_d;
  logic [JUMP_W-1:0]   id_jump_q, id_jump_d;
  logic                wen_q, wen_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [LEN_W-1:0]    len_calc;
  logic [LaneW-1:0]    rem;
  logic [LEN_W-1:0]    beats_floor;
  logic [LANES-1:0]    tail_mask;
  logic                adv;
  logic                is_last;

  assign len_calc    = LEN_W'(BASE_LEN) + LEN_W'(link_q) * LEN_W'(LEN_STEP);
  assign rem         = len_calc[LaneW-1:0];
  assign beats_floor = len_calc >> LaneW;
  assign tail_mask   = (LANES'(1) << rem) - LANES'(1);
  assign adv         = mode_q | din_vld_i;
  assign is_last     = (beat_q == last_idx_q);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    link_d     = link_q;
    m_len_d    = m_len_q;
    last_idx_d = last_idx_q;
    last_en_d  = last_en_q;
    beat_d     = beat_q;
    enable_d   = enable_q;
    id_jump_d  = id_jump_q;
    wen_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (request_i) begin
          link_d  = link_id_i;
          mode_d  = mode_i;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        m_len_d = len_calc;
        // Index of the final beat: ceil(len/LANES)-1.
        last_idx_d = JUMP_W'(beats_floor) - ((rem == '0) ? JUMP_W'(1) : '0);
        last_en_d  = (rem == '0) ? '1 : tail_mask;
        beat_d     = '0;
        state_d    = StRun;
      end
      StRun: begin
        if (adv) begin
          wen_d     = 1'b1;
          id_jump_d = beat_q;
          enable_d  = is_last ? last_en_q : '1;
          beat_d    = beat_q + JUMP_W'(1);
          if (is_last) begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything except in idle, where it is a no-op.
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      m_len_d   = m_len_q;
      wen_d     = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      enable_d  = '0;
      id_jump_d = '0;
      beat_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      link_q     <= '0;
      m_len_q    <= '0;
      last_idx_q <= '0;
      last_en_q  <= '0;
      beat_q     <= '0;
      enable_q   <= '0;
      id_jump_q  <= '0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      link_q     <= link_d;
      m_len_q    <= m_len_d;
      last_idx_q <= last_idx_d;
      last_en_q  <= last_en_d;
      beat_q     <= beat_d;
      enable_q   <= enable_d;
      id_jump_q  <= id_jump_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign enable_o  = enable_q;
  assign id_jump_o = id_jump_q;
  assign wen_o     = wen_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign m_len_o   = m_len_q;

endmodule

// File: tb/tb_turbo_len_ctrl.sv
// Directed bench for turbo_len_ctrl: a 16-lane and an 8-lane instance share one stimulus.
module tb_turbo_len_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        request, abort, mode, din_vld;
  logic [5:0]  link_id;

  logic [15:0] en16, id16;
  logic        wen16, busy16, done16;
  logic [12:0] mlen16;
  logic [7:0]  en8;
  logic [15:0] id8;
  logic        wen8, busy8, done8;
  logic [12:0] mlen8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  turbo_len_ctrl #(.LANES(16)) u16 (
    .clk_i(clk), .n_rst_i(n_rst), .request_i(request), .abort_i(abort), .mode_i(mode),
    .link_id_i(link_id), .din_vld_i(din_vld), .enable_o(en16), .id_jump_o(id16),
    .wen_o(wen16), .busy_o(busy16), .done_o(done16), .m_len_o(mlen16)
  );

  turbo_len_ctrl #(.LANES(8)) u8 (
    .clk_i(clk), .n_rst_i(n_rst), .request_i(request), .abort_i(abort), .mode_i(mode),
    .link_id_i(link_id), .din_vld_i(din_vld), .enable_o(en8), .id_jump_o(id8),
    .wen_o(wen8), .busy_o(busy8), .done_o(done8), .m_len_o(mlen8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    request = 1'b0; din_vld = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  task automatic start(input logic [5:0] id, input logic md);
    link_id = id; mode = md; request = 1'b1;
    step();
    request = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; request = 1'b0; abort = 1'b0; mode = 1'b0; din_vld = 1'b0; link_id = '0;
    step(); step();
    total++;
    if ({wen16, busy16, done16, en16, id16, mlen16} !== '0)
      $display("FAIL reset16: got %h want 0", {wen16, busy16, done16, en16, id16, mlen16});
    else passed++;
    total++;
    if ({wen8, busy8, done8, en8, id8, mlen8} !== '0)
      $display("FAIL reset8: got %h want 0", {wen8, busy8, done8, en8, id8, mlen8});
    else passed++;
    #2 n_rst = 1'b1;
    step();
    total++;
    if (busy16 !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy16);
    else passed++;
  endtask

  task automatic test_write_frame();
    logic [15:0] exp_en [3];
    exp_en = '{16'hFFFF, 16'hFFFF, 16'h00FF};
    din_vld = 1'b1;
    start(6'd0, 1'b0);
    total++;
    if ({busy16, wen16} !== 2'b10) $display("FAIL load_busy: got %b want 10", {busy16, wen16});
    else passed++;
    step();
    total++;
    if ({mlen16, wen16} !== {13'd40, 1'b0})
      $display("FAIL mlen40: got %0d/%b want 40/0", mlen16, wen16);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({wen16, busy16, done16, id16, en16} !== {1'b1, 1'b1, (i == 2), 16'(i), exp_en[i]})
        $display("FAIL wbeat%0d: got w%b b%b d%b id%0d en%h want id%0d en%h", i, wen16,
                 busy16, done16, id16, en16, i, exp_en[i]);
      else passed++;
    end
    step();
    total++;
    if ({busy16, done16, wen16} !== 3'b000)
      $display("FAIL wend: got %b want 000", {busy16, done16, wen16});
    else passed++;
    settle();
  endtask

  task automatic test_lanes8();
    din_vld = 1'b1;
    start(6'd0, 1'b0);
    step();
    total++;
    if (mlen8 !== 13'd40) $display("FAIL mlen8: got %0d want 40", mlen8);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({wen8, done8, id8, en8} !== {1'b1, (i == 4), 16'(i), 8'hFF})
        $display("FAIL l8beat%0d: got w%b d%b id%0d en%h want id%0d en ff", i, wen8, done8,
                 id8, en8, i);
      else passed++;
    end
    step();
    total++;
    if (busy8 !== 1'b0) $display("FAIL l8busy: got %b want 0", busy8);
    else passed++;
    settle();
  endtask

  task automatic test_gated();
    int beat = 0;
    din_vld = 1'b0;
    start(6'd1, 1'b0);
    step();
    total++;
    if (mlen16 !== 13'd104) $display("FAIL mlen104: got %0d want 104", mlen16);
    else passed++;
    for (int k = 0; k < 40 && beat < 7; k++) begin
      din_vld = ((k % 3) == 0);
      step();
      total++;
      if (din_vld) begin
        if ({wen16, done16, id16, en16} !==
            {1'b1, (beat == 6), 16'(beat), (beat == 6) ? 16'h00FF : 16'hFFFF})
          $display("FAIL gbeat%0d: got w%b d%b id%0d en%h", beat, wen16, done16, id16, en16);
        else passed++;
        beat++;
      end else begin
        if ({wen16, id16} !== {1'b0, 16'(beat - 1)})
          $display("FAIL ghold%0d: got w%b id%0d want w0 id%0d", k, wen16, id16, beat - 1);
        else passed++;
      end
    end
    din_vld = 1'b0;
    step();
    total++;
    if ({busy16, done16} !== 2'b00) $display("FAIL gend: got %b want 00", {busy16, done16});
    else passed++;
    settle();
  endtask

  task automatic test_read_long();
    din_vld = 1'b0;
    start(6'd63, 1'b1);
    total++;
    if (wen16 !== 1'b0) $display("FAIL rlat1: got %b want 0", wen16);
    else passed++;
    step();
    total++;
    if ({mlen16, wen16} !== {13'd4072, 1'b0})
      $display("FAIL rlat2: got %0d/%b want 4072/0", mlen16, wen16);
    else passed++;
    for (int i = 0; i < 255; i++) begin
      step();
      total++;
      if ({wen16, done16, id16, en16} !==
          {1'b1, (i == 254), 16'(i), (i == 254) ? 16'h00FF : 16'hFFFF})
        $display("FAIL rbeat%0d: got w%b d%b id%0d en%h", i, wen16, done16, id16, en16);
      else passed++;
    end
    step();
    total++;
    if ({busy16, wen16, done16} !== 3'b000)
      $display("FAIL rend: got %b want 000", {busy16, wen16, done16});
    else passed++;
    settle();
  endtask

  task automatic test_abort();
    din_vld = 1'b0;
    start(6'd1, 1'b1);
    link_id = 6'd5; request = 1'b1;
    step();
    request = 1'b0;
    total++;
    if (mlen16 !== 13'd104) $display("FAIL ab_mlen: got %0d want 104", mlen16);
    else passed++;
    step();
    request = 1'b1; link_id = 6'd9;
    step();
    request = 1'b0;
    total++;
    if ({wen16, id16} !== {1'b1, 16'd1}) $display("FAIL ab_id1: got %b/%0d want 1/1", wen16, id16);
    else passed++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if ({wen16, busy16, done16, en16, id16, mlen16} !== {35'd0, 13'd104})
      $display("FAIL ab_clear: got w%b b%b d%b en%h id%0d m%0d want 0s m104", wen16, busy16,
               done16, en16, id16, mlen16);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({busy16, done16, wen16} !== 3'b000)
        $display("FAIL ab_quiet%0d: got %b want 000", i, {busy16, done16, wen16});
      else passed++;
    end
    link_id = 6'd1; mode = 1'b1; request = 1'b1; abort = 1'b1;
    step();
    request = 1'b0; abort = 1'b0;
    total++;
    if (busy16 !== 1'b1) $display("FAIL ab_reqwin: got %b want 1", busy16);
    else passed++;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if ({wen16, done16, id16, en16} !==
          {1'b1, (i == 6), 16'(i), (i == 6) ? 16'h00FF : 16'hFFFF})
        $display("FAIL ab_beat%0d: got w%b d%b id%0d en%h", i, wen16, done16, id16, en16);
      else passed++;
    end
    step();
    total++;
    if (busy16 !== 1'b0) $display("FAIL ab_end: got %b want 0", busy16);
    else passed++;
    settle();
  endtask

  task automatic test_reset_mid();
    din_vld = 1'b0;
    start(6'd63, 1'b1);
    step(); step(); step();
    total++;
    if ({wen16, id16} !== {1'b1, 16'd1}) $display("FAIL rm_run: got %b/%0d want 1/1", wen16, id16);
    else passed++;
    #1 n_rst = 1'b0;
    #1;
    total++;
    if ({wen16, busy16, done16, en16, id16, mlen16} !== '0)
      $display("FAIL rm_async16: got %h want 0", {wen16, busy16, done16, en16, id16, mlen16});
    else passed++;
    total++;
    if ({wen8, busy8, done8, en8, id8, mlen8} !== '0)
      $display("FAIL rm_async8: got %h want 0", {wen8, busy8, done8, en8, id8, mlen8});
    else passed++;
    #1 n_rst = 1'b1;
    step();
    total++;
    if ({busy16, wen16, done16} !== 3'b000)
      $display("FAIL rm_idle: got %b want 000", {busy16, wen16, done16});
    else passed++;
    start(6'd0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({wen16, done16, id16} !== {1'b1, (i == 2), 16'(i)})
        $display("FAIL rm_beat%0d: got w%b d%b id%0d", i, wen16, done16, id16);
      else passed++;
    end
    step();
    total++;
    if (busy16 !== 1'b0) $display("FAIL rm_end: got %b want 0", busy16);
    else passed++;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_frame();
    test_lanes8();
    test_gated();
    test_read_long();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
